// File: rtl/custom_cpu_axil_slave_mem_pkg.sv
// Shared types and constants for the CustomCPU AXI4-Lite word-memory slave.
package custom_cpu_axi_pkg;

  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/custom_cpu_axil_slave_mem_if.sv
// AXI4-Lite bus bundle between the CPU memory_bus master and the word memory.
interface custom_cpu_axil_slave_mem_if #(
  parameter int ADDR_WIDTH = 12
);
  import custom_cpu_axi_pkg::*;

  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic [2:0]            S_AXI_AWPROT;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [AXI_DATA_W-1:0] S_AXI_WDATA;
  logic [AXI_STRB_W-1:0] S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [2:0]            S_AXI_ARPROT;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [AXI_DATA_W-1:0] S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
    input S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input S_AXI_ARREADY,
    input S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
  );

  modport slave (
    input S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
    input S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
    input S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
  );

endinterface

// File: rtl/custom_cpu_axil_slave_mem_ram.sv
// Byte-enabled word RAM, one write port and one registered read port.
// No reset anywhere so the array maps onto block RAM; a read and a write to
// the same word on the same edge return the old contents.
module custom_cpu_word_ram
  import custom_cpu_axi_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [AXI_DATA_W-1:0] wdata_i,
  input  logic [AXI_STRB_W-1:0] wbe_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [AXI_DATA_W-1:0] rdata_o
);

  logic [AXI_DATA_W-1:0] mem_q [DEPTH];
  logic [AXI_DATA_W-1:0] rdata_q;

  // Byte-lane write
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < AXI_STRB_W; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Registered read, held until the next read enable
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/custom_cpu_axil_slave_mem.sv
// AXI4-Lite slave word memory answering the CustomCPU memory_bus master.
// Independent write and read channel FSMs; out-of-range words answer SLVERR.
module custom_cpu_axil_slave_mem
  import custom_cpu_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int MEM_DEPTH_WORDS    = 256
) (
  input logic                        ACLK,
  input logic                        ARESETN,
  custom_cpu_axil_slave_mem_if.slave s_axi
);

  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int RAM_AW = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;

  if (C_S_AXI_DATA_WIDTH != AXI_DATA_W) begin : g_chk_dw
    $error("custom_cpu_axil_slave_mem supports only 32-bit data");
  end
  if (MEM_DEPTH_WORDS > (1 << IDX_W)) begin : g_chk_depth
    $error("MEM_DEPTH_WORDS exceeds the addressable word range");
  end

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < MEM_DEPTH_WORDS;
  endfunction

  // write channel
  wr_state_t             wr_state_q, wr_state_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic [AXI_DATA_W-1:0] wdata_q, wdata_d;
  logic [AXI_STRB_W-1:0] wstrb_q, wstrb_d;
  axi_resp_t             bresp_q, bresp_d;
  logic                  aw_fire, w_fire, wr_commit, ram_we;
  logic [IDX_W-1:0]      wr_idx;
  logic [AXI_DATA_W-1:0] wr_data;
  logic [AXI_STRB_W-1:0] wr_strb;

  // read channel
  rd_state_t             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  axi_resp_t             rresp_q, rresp_d;
  logic                  ar_fire;
  logic [IDX_W-1:0]      ar_idx;
  logic [AXI_DATA_W-1:0] ram_rdata;

  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  assign aw_fire = s_axi.S_AXI_AWVALID & awready_q;
  assign w_fire  = s_axi.S_AXI_WVALID & wready_q;
  assign ar_fire = s_axi.S_AXI_ARVALID & arready_q;
  assign ar_idx  = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // A half arriving on this edge is used directly so the write commits on
  // the same edge as the later of the two handshakes.
  assign wr_idx  = aw_held_q ? aw_idx_q : s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_data = w_held_q ? wdata_q : s_axi.S_AXI_WDATA;
  assign wr_strb = w_held_q ? wstrb_q : s_axi.S_AXI_WSTRB;
  assign ram_we  = wr_commit & idx_in_range(wr_idx);

  // Write FSM next state, capture of AW/W halves and response
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.S_AXI_WDATA;
          wstrb_d  = s_axi.S_AXI_WSTRB;
        end
        if (aw_held_d && w_held_d) begin
          wr_commit  = 1'b1;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bresp_d    = idx_in_range(wr_idx) ? OKAY : SLVERR;
          wr_state_d = W_RESP;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
        end else begin
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      W_RESP: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        if (s_axi.S_AXI_BREADY) begin
          wr_state_d = W_IDLE;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write channel registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

  // Read FSM next state and response
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_fire) begin
          rd_state_d = R_DATA;
          arready_d  = 1'b0;
          rresp_d    = idx_in_range(ar_idx) ? OKAY : SLVERR;
        end
      end
      R_DATA: begin
        arready_d = 1'b0;
        if (s_axi.S_AXI_RREADY) begin
          rd_state_d = R_IDLE;
          arready_d  = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read channel registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rresp_q    <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rresp_q    <= rresp_d;
    end
  end

  custom_cpu_word_ram #(
    .DEPTH (MEM_DEPTH_WORDS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk_i   (ACLK),
    .we_i    (ram_we),
    .waddr_i (wr_idx[RAM_AW-1:0]),
    .wdata_i (wr_data),
    .wbe_i   (wr_strb),
    .re_i    (ar_fire),
    .raddr_i (ar_idx[RAM_AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = (wr_state_q == W_RESP);
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = (rd_state_q == R_DATA);
  assign s_axi.S_AXI_RRESP   = rresp_q;
  // RAM output has no reset; gating keeps RDATA at zero in reset and idle
  // and forces zero for out-of-range reads.
  assign s_axi.S_AXI_RDATA   = (rd_state_q == R_DATA && rresp_q == OKAY) ? ram_rdata : '0;

endmodule

// File: tb/tb_custom_cpu_axil_slave_mem.sv
// Scoreboard bench for the AXI4-Lite word memory slave.
module tb_custom_cpu_axil_slave_mem;
  import custom_cpu_axi_pkg::*;

  logic aclk;
  logic aresetn;

  custom_cpu_axil_slave_mem_if #(.ADDR_WIDTH(12)) bus ();

  custom_cpu_axil_slave_mem #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (12),
    .MEM_DEPTH_WORDS    (256)
  ) dut (
    .ACLK    (aclk),
    .ARESETN (aresetn),
    .s_axi   (bus.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;
  int b_count  = 0;

  logic [1:0]  bq [$];
  logic [31:0] rq_data [$];
  logic [1:0]  rq_resp [$];
  logic [31:0] model [0:255];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  // response monitor: a handshake seen at the negedge completes on the next posedge
  always @(negedge aclk) begin
    if (aresetn) begin
      if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
        b_count++;
        if (bq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else check("bresp", {30'd0, bus.S_AXI_BRESP}, {30'd0, bq.pop_front()});
      end
      if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
        if (rq_data.size() == 0) check("r_unexpected", 32'd1, 32'd0);
        else begin
          check("rdata", bus.S_AXI_RDATA, rq_data.pop_front());
          check("rresp", {30'd0, bus.S_AXI_RRESP}, {30'd0, rq_resp.pop_front()});
        end
      end
    end
  end

  function automatic logic in_rng(input logic [11:0] addr);
    return addr[11:2] < 10'd256;
  endfunction

  // Drive one write; lead>0 presents W that many cycles before AW, lead<0 AW first.
  task automatic wr_handshake(input logic [11:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int lead);
    int aw_at, w_at;
    logic aw_done, w_done, hs_aw, hs_w;
    aw_at = (lead > 0) ? lead : 0;
    w_at  = (lead < 0) ? -lead : 0;
    aw_done = 1'b0;
    w_done  = 1'b0;
    bq.push_back(in_rng(addr) ? OKAY : SLVERR);
    if (in_rng(addr))
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr[9:2]][8*b +: 8] = data[8*b +: 8];
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      if (c == aw_at) begin bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_AWADDR = addr; end
      if (c == w_at) begin bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb; end
      @(negedge aclk);
      if (w_done && !aw_done) check("wready_while_held", {31'd0, bus.S_AXI_WREADY}, 32'd0);
      if (aw_done && !w_done) check("awready_while_held", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
      hs_aw = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      hs_w  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(posedge aclk); #1;
      if (hs_aw) begin aw_done = 1'b1; bus.S_AXI_AWVALID = 1'b0; end
      if (hs_w)  begin w_done  = 1'b1; bus.S_AXI_WVALID  = 1'b0; end
    end
    if (!(aw_done && w_done)) check("wr_hs_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int stall);
    logic [1:0] exp;
    exp = in_rng(addr) ? OKAY : SLVERR;
    bus.S_AXI_BREADY = (stall == 0);
    wr_handshake(addr, data, strb, lead);
    @(negedge aclk);
    check("b_latency", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    for (int s = 0; s < stall; s++) begin
      if (s > 0) @(negedge aclk);
      check("b_hold_valid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
      check("b_hold_resp", {30'd0, bus.S_AXI_BRESP}, {30'd0, exp});
      check("b_hold_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    end
    @(posedge aclk); #1;
    bus.S_AXI_BREADY = 1'b1;
    for (int i = 0; i < 20 && bq.size() != 0; i++) begin @(posedge aclk); #1; end
    check("b_drain", bq.size(), 32'd0);
  endtask

  task automatic do_read(input logic [11:0] addr, input int stall);
    logic [31:0] exp_d;
    logic hs;
    exp_d = in_rng(addr) ? model[addr[9:2]] : 32'h0;
    rq_data.push_back(exp_d);
    rq_resp.push_back(in_rng(addr) ? OKAY : SLVERR);
    bus.S_AXI_RREADY  = (stall == 0);
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_ARADDR  = addr;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge aclk);
      hs = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      @(posedge aclk); #1;
    end
    bus.S_AXI_ARVALID = 1'b0;
    if (!hs) check("ar_hs_timeout", 32'd0, 32'd1);
    @(negedge aclk);
    check("r_latency", {31'd0, bus.S_AXI_RVALID}, 32'd1);
    for (int s = 0; s < stall; s++) begin
      if (s > 0) @(negedge aclk);
      check("r_hold_valid", {31'd0, bus.S_AXI_RVALID}, 32'd1);
      check("r_hold_data", bus.S_AXI_RDATA, exp_d);
      check("r_hold_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd0);
    end
    @(posedge aclk); #1;
    bus.S_AXI_RREADY = 1'b1;
    for (int i = 0; i < 20 && rq_data.size() != 0; i++) begin @(posedge aclk); #1; end
    check("r_drain", rq_data.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    check({tag, "_wready"},  {31'd0, bus.S_AXI_WREADY},  32'd0);
    check({tag, "_arready"}, {31'd0, bus.S_AXI_ARREADY}, 32'd0);
    check({tag, "_bvalid"},  {31'd0, bus.S_AXI_BVALID},  32'd0);
    check({tag, "_rvalid"},  {31'd0, bus.S_AXI_RVALID},  32'd0);
    check({tag, "_bresp"},   {30'd0, bus.S_AXI_BRESP},   32'd0);
    check({tag, "_rresp"},   {30'd0, bus.S_AXI_RRESP},   32'd0);
    check({tag, "_rdata"},   bus.S_AXI_RDATA,            32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    aresetn = 1'b0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;

    repeat (2) @(posedge aclk);
    #1;
    check_reset_outputs("rst");
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("ready_before_edge", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    @(posedge aclk); #1;
    check("awready_rise", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    check("wready_rise",  {31'd0, bus.S_AXI_WREADY},  32'd1);
    check("arready_rise", {31'd0, bus.S_AXI_ARREADY}, 32'd1);

    // basic write/read and byte strobes
    do_write(12'h000, 32'h0BAD_CAFE, 4'hF, 0, 0);
    do_write(12'h010, 32'h1234_5678, 4'hF, 0, 0);
    do_read(12'h010, 0);
    do_write(12'h010, 32'hAABB_CCDD, 4'b0101, 0, 0);
    do_read(12'h010, 0);
    do_read(12'h013, 0);

    // W leads AW by 3 cycles, then AW/W together: one B each
    b0 = b_count;
    do_write(12'h014, 32'h0102_0304, 4'hF, 3, 0);
    do_write(12'h018, 32'h5566_7788, 4'hF, 0, 0);
    do_write(12'h01C, 32'h9ABC_DEF0, 4'hF, -2, 0);
    check("b_count", b_count, b0 + 3);
    do_read(12'h014, 0);
    do_read(12'h018, 0);
    do_read(12'h01C, 0);

    // out of range
    do_write(12'h400, 32'hFFFF_FFFF, 4'hF, 0, 0);
    do_read(12'h400, 0);
    do_read(12'hFFC, 0);
    do_read(12'h000, 0);

    // WSTRB=0 leaves memory alone
    do_write(12'h010, 32'hFFFF_FFFF, 4'h0, 0, 0);
    do_read(12'h010, 0);

    // backpressure on B and R
    do_write(12'h020, 32'hCAFE_F00D, 4'hF, 0, 5);
    do_read(12'h020, 5);

    // read/write collision on one word
    do_write(12'h040, 32'h5555_AAAA, 4'hF, 0, 0);
    bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = 32'h7777_8888; bus.S_AXI_WSTRB = 4'hF;
    @(negedge aclk);
    check("col_w_hs", {31'd0, bus.S_AXI_WREADY}, 32'd1);
    @(posedge aclk); #1;
    bus.S_AXI_WVALID = 1'b0;
    rq_data.push_back(model[16]);
    rq_resp.push_back(OKAY);
    bq.push_back(OKAY);
    model[16] = 32'h7777_8888;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_AWADDR = 12'h040;
    bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_ARADDR = 12'h040;
    @(negedge aclk);
    check("col_aw_hs", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    check("col_ar_hs", {31'd0, bus.S_AXI_ARREADY}, 32'd1);
    @(posedge aclk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 20 && (bq.size() != 0 || rq_data.size() != 0); i++) begin
      @(posedge aclk); #1;
    end
    check("col_drain", bq.size() + rq_data.size(), 32'd0);
    do_read(12'h040, 0);

    // reset while BVALID high and a W pending
    bus.S_AXI_BREADY = 1'b0;
    wr_handshake(12'h024, 32'h1357_9BDF, 4'hF, 0);
    @(negedge aclk);
    check("pre_rst_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = 32'hDEAD_BEEF; bus.S_AXI_WSTRB = 4'hF;
    #2;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    bq.delete();
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    do_read(12'h024, 0);

    // W latched alone, then reset: it must be discarded
    bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = 32'h1111_1111; bus.S_AXI_WSTRB = 4'hF;
    @(negedge aclk);
    check("held_w_hs", {31'd0, bus.S_AXI_WREADY}, 32'd1);
    @(posedge aclk); #1;
    bus.S_AXI_WVALID = 1'b0;
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("held_rst_wready", {31'd0, bus.S_AXI_WREADY}, 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    do_write(12'h030, 32'h2222_2222, 4'hF, -2, 0);
    do_read(12'h030, 0);
    do_read(12'h020, 0);
    do_read(12'h000, 0);

    repeat (3) @(posedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
